mac_feed_ctrl: RTL

Sequencer that streams operand words from the operand SRAM into the row input buffers of the 4-row MAC array. It issues one SRAM read every 4 cycles and re-times each returned row word with a row-dependent skew, so row r receives its load pulse r cycles after row 0 (systolic wavefront). It then waits for the array to drain and signals completion. It sits between the top-level control FSM (Start/Done) and the per-row input buffers (IWord/EN).

---
 rtl/mac_pkg.sv | 15 +
 rtl/skew_delay.sv | 44 ++++
 rtl/mac_feed_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array operand feed path.
package mac_pkg;

  localparam int ARRAY_ROWS = 4;
  localparam int WORD_W     = 32;
  localparam int PH_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/skew_delay.sv
// Register chain of DEPTH stages carrying a word together with its valid bit.
// A stage only reloads its word when a valid word arrives, so the output word
// is held between loads. DEPTH = 0 is a plain pass-through.
module skew_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_vld  = i_vld;
      assign o_data = i_data;
    end else begin : g_chain
      logic [DEPTH-1:0] r_vld;
      logic [WIDTH-1:0] r_data [DEPTH];

      // Shift valid every cycle; advance a word only alongside its valid bit.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_vld <= '0;
          for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
          r_vld[0] <= i_vld;
          if (i_vld) r_data[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) r_data[i] <= r_data[i-1];
          end
        end
      end

      assign o_vld  = r_vld[DEPTH-1];
      assign o_data = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mac_feed_ctrl.sv
// Streams operand words from the SRAM into the MAC array row buffers: one
// read every 4 cycles, row r loaded r cycles after row 0, then a drain wait.
module mac_feed_ctrl
  import mac_pkg::*;
#(
  parameter int ROWS      = ARRAY_ROWS,
  parameter int AW        = 8,
  parameter int DRAIN_CYC = 12
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic [AW-1:0]          BaseAddr,
  input  logic [AW-1:0]          NumVec,
  output logic                   MemRE,
  output logic [AW-1:0]          MemAddr,
  input  logic [WORD_W*ROWS-1:0] MemRData,
  output logic [WORD_W*ROWS-1:0] IWord,
  output logic [ROWS-1:0]        EN,
  output logic                   Busy,
  output logic                   Done
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [DCW-1:0] DCNT_END = DCW'(DRAIN_CYC - 1);
  localparam logic [DCW-1:0] DCNT_MAX = {DCW{1'b1}};
  localparam logic [PH_W-1:0] PH_LAST = {PH_W{1'b1}};

  state_t                  r_state;
  state_t                  w_next;
  logic [AW-1:0]           r_base;
  logic [AW-1:0]           r_num;
  logic [AW-1:0]           r_k;
  logic [PH_W-1:0]         r_ph;
  logic                    r_re_p0;
  logic                    r_vld_p1;
  logic [WORD_W*ROWS-1:0]  r_data_p1;
  logic [DCW-1:0]          r_dcnt;
  logic                    r_armed;
  logic                    w_last_k;

  assign w_last_k = (r_k == r_num - 1'b1);

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next  = r_state;
    MemRE   = 1'b0;
    MemAddr = '0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) w_next = (NumVec != '0) ? FEED : DONE;
      end
      FEED: begin
        Busy = 1'b1;
        if (r_ph == '0) begin
          MemRE   = 1'b1;
          MemAddr = r_base + r_k;
        end
        if (r_ph == PH_LAST && w_last_k) w_next = DRAIN;
      end
      DRAIN: begin
        Busy = 1'b1;
        if (r_armed && r_dcnt == DCNT_END) w_next = DONE;
      end
      DONE: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register, latched job parameters, phase and word counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_num   <= '0;
      r_k     <= '0;
      r_ph    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && Start) begin
        r_base <= BaseAddr;
        r_num  <= NumVec;
        r_k    <= '0;
        r_ph   <= '0;
      end else if (r_state == FEED) begin
        r_ph <= r_ph + 1'b1;
        if (r_ph == PH_LAST && !w_last_k) r_k <= r_k + 1'b1;
      end
    end
  end

  // Drain timer restarts on every last-row load and runs while armed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_armed <= 1'b0;
      r_dcnt  <= '0;
    end else if (r_state == IDLE || r_state == DONE) begin
      r_armed <= 1'b0;
      r_dcnt  <= '0;
    end else if (EN[ROWS-1]) begin
      r_armed <= 1'b1;
      r_dcnt  <= '0;
    end else if (r_armed && r_dcnt != DCNT_MAX) begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  // p0: read in flight; p1: returned SRAM word captured (stage 0 of the skew).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_re_p0   <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_re_p0  <= MemRE;
      r_vld_p1 <= r_re_p0;
      if (r_re_p0) r_data_p1 <= MemRData;
    end
  end

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      skew_delay #(
        .DEPTH(r),
        .WIDTH(WORD_W)
      ) u_skew (
        .CLK    (CLK),
        .RST    (RST),
        .i_vld  (r_vld_p1),
        .i_data (r_data_p1[WORD_W*r +: WORD_W]),
        .o_vld  (EN[r]),
        .o_data (IWord[WORD_W*r +: WORD_W])
      );
    end
  endgenerate

endmodule
